// File: rtl/key_debounce_multi.sv
// key_debounce_multi: per-key 2-flop synchroniser + stability counter, press/release pulses, press code.
// Define KEY_DEB_LONG_PRESS_EN to add one-shot long-press pulses on key_long_n.
module key_debounce_multi #(
  parameter int          NUM_KEYS    = 4,
  parameter logic [15:0] DEB_CYCLES  = 16'd100,
  parameter int          CNT_W       = 16,
  parameter logic [31:0] LONG_CYCLES = 32'd1000000,
  parameter int          CODE_W      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_state_n,
  output logic [NUM_KEYS-1:0] key_pulse_n,
  output logic [NUM_KEYS-1:0] key_rel_pulse_n,
  output logic [NUM_KEYS-1:0] key_long_n,
  output logic                key_valid,
  output logic [CODE_W-1:0]   key_code
);
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_CYCLES - 16'd1);
  if (NUM_KEYS < 1 || NUM_KEYS > 16 || int'(DEB_CYCLES) < 2 || (CNT_W < 32 && (1 << CNT_W) <= int'(DEB_CYCLES)) ||
      (1 << CODE_W) < NUM_KEYS || LONG_CYCLES < 32'd2) begin : g_bad_params
    $error("key_debounce_multi: illegal parameter combination");
  end
  logic [NUM_KEYS-1:0] r_s1, r_s, r_state, r_pulse, r_rel;
  logic                r_valid;
  logic [CODE_W-1:0]   r_code;
  logic [NUM_KEYS-1:0] w_acc, w_press, w_rel;
  logic [CODE_W-1:0]   w_code;
  assign w_press = w_acc & ~r_s;
  assign w_rel   = w_acc & r_s;
  always_comb begin
    w_code = r_code;
    for (int i = NUM_KEYS - 1; i >= 0; i--) w_code = w_press[i] ? CODE_W'(i) : w_code;
  end
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    assign w_acc[k] = (r_s[k] != r_state[k]) && (r_cnt == DEB_MAX);
    always_ff @(posedge clk) begin
      if (!rst_n) r_cnt <= '0;
      else        r_cnt <= (r_s[k] == r_state[k] || w_acc[k]) ? '0 : r_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1    <= '1;
      r_s     <= '1;
      r_state <= '1;
      r_pulse <= '1;
      r_rel   <= '1;
      r_valid <= 1'b0;
      r_code  <= '0;
    end else begin
      r_s1    <= key_n;
      r_s     <= r_s1;
      r_state <= r_state ^ w_acc;
      r_pulse <= ~w_press;
      r_rel   <= ~w_rel;
      r_valid <= |w_press;
      r_code  <= w_code;
    end
  end
  assign key_state_n     = r_state;
  assign key_pulse_n     = r_pulse;
  assign key_rel_pulse_n = r_rel;
  assign key_valid       = r_valid;
  assign key_code        = r_code;
`ifdef KEY_DEB_LONG_PRESS_EN
  // Hold counter saturates one past the trigger value so the pulse fires once per press.
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_long
    logic [31:0] r_hold;
    logic        r_lp;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_hold <= '0;
        r_lp   <= 1'b1;
      end else begin
        r_hold <= (r_state[k] || w_acc[k]) ? '0 : (r_hold == LONG_CYCLES ? r_hold : r_hold + 32'd1);
        r_lp   <= !(!r_state[k] && !w_acc[k] && r_hold == LONG_CYCLES - 32'd1);
      end
    end
    assign key_long_n[k] = r_lp;
  end
`else
  assign key_long_n = '1;
`endif
endmodule

// File: tb/tb_key_debounce_multi.sv
// tb_key_debounce_multi: directed and randomized checks against a sliding-window debounce model.
module tb_key_debounce_multi;
  localparam int NK  = 4;
  localparam int DEB = 100;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NK-1:0] key_n = '1;
  logic [NK-1:0] key_state_n, key_pulse_n, key_rel_pulse_n, key_long_n;
  logic key_valid;
  logic [3:0] key_code;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  key_debounce_multi #(
    .NUM_KEYS(NK), .DEB_CYCLES(16'd100), .CNT_W(16), .LONG_CYCLES(32'd1000000), .CODE_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_n(key_n), .key_state_n(key_state_n), .key_pulse_n(key_pulse_n),
    .key_rel_pulse_n(key_rel_pulse_n), .key_long_n(key_long_n), .key_valid(key_valid), .key_code(key_code)
  );
  // Model: a level is accepted when the synchronised pin (raw pin two edges late)
  // has disagreed with the debounced level for the last DEB edges in a row.
  logic [NK-1:0] hist[$];
  logic [NK-1:0] m_state = '1, m_pulse = '1, m_rel = '1;
  logic m_valid = 1'b0;
  logic [3:0] m_code = '0;
  int run;
  always @(posedge clk) begin
    if (!rst_n) begin
      hist.delete();
      hist.push_back('1);
      hist.push_back('1);
      m_state = '1; m_pulse = '1; m_rel = '1; m_valid = 1'b0; m_code = '0;
    end else begin
      hist.push_back(key_n);
      if (hist.size() > DEB + 2) void'(hist.pop_front());
      m_pulse = '1;
      m_rel = '1;
      if (hist.size() == DEB + 2)
        for (int i = 0; i < NK; i++) begin
          run = 0;
          for (int k = 0; k < DEB; k++) if (hist[k][i] != m_state[i]) run++;
          if (run == DEB) begin
            m_state[i] = ~m_state[i];
            if (m_state[i]) m_rel[i] = 1'b0; else m_pulse[i] = 1'b0;
          end
        end
      m_valid = ~&m_pulse;
      for (int i = NK - 1; i >= 0; i--) if (!m_pulse[i]) m_code = 4'(i);
    end
  end
  logic [20:0] dut_v, mdl_v;
  assign dut_v = {key_state_n, key_pulse_n, key_rel_pulse_n, key_long_n, key_valid, key_code};
  assign mdl_v = {m_state, m_pulse, m_rel, 4'hF, m_valid, m_code};

  task automatic test_reset();
    rst_n = 1'b0;
    key_n = '1;
    repeat (2) @(negedge clk);
    checks++; if (key_state_n !== 4'hF) begin failures++; $display("FAIL reset_state got %h want f", key_state_n); end
    checks++; if (key_pulse_n !== 4'hF) begin failures++; $display("FAIL reset_pulse got %h want f", key_pulse_n); end
    checks++; if (key_rel_pulse_n !== 4'hF) begin failures++; $display("FAIL reset_rel got %h want f", key_rel_pulse_n); end
    checks++; if (key_long_n !== 4'hF) begin failures++; $display("FAIL reset_long got %h want f", key_long_n); end
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b want 0", key_valid); end
    checks++; if (key_code !== 4'd0) begin failures++; $display("FAIL reset_code got %0d want 0", key_code); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_clean_press();
    int p_edge = -1, p_cnt = 0, r_edge = -1, r_cnt = 0;
    key_n[2] = 1'b0;
    for (int e = 1; e <= 200; e++) begin
      @(negedge clk);
      checks++; if (dut_v !== mdl_v) begin failures++; $display("FAIL press_model edge %0d got %h want %h", e, dut_v, mdl_v); end
      if (key_pulse_n[2] === 1'b0) begin
        p_cnt++;
        if (p_edge < 0) p_edge = e;
        checks++; if ({key_valid, key_code} !== 5'b1_0010) begin failures++; $display("FAIL press_code got %b/%0d want 1/2", key_valid, key_code); end
      end
    end
    checks++; if (p_edge != DEB + 2 || p_cnt != 1) begin failures++; $display("FAIL press_timing got edge %0d count %0d want edge 102 count 1", p_edge, p_cnt); end
    checks++; if (key_state_n[2] !== 1'b0) begin failures++; $display("FAIL press_level got %b want 0", key_state_n[2]); end
    key_n[2] = 1'b1;
    for (int e = 1; e <= 200; e++) begin
      @(negedge clk);
      checks++; if (dut_v !== mdl_v) begin failures++; $display("FAIL release_model edge %0d got %h want %h", e, dut_v, mdl_v); end
      checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL release_valid edge %0d got %b want 0", e, key_valid); end
      if (key_rel_pulse_n[2] === 1'b0) begin r_cnt++; if (r_edge < 0) r_edge = e; end
    end
    checks++; if (r_edge != DEB + 2 || r_cnt != 1) begin failures++; $display("FAIL release_timing got edge %0d count %0d want edge 102 count 1", r_edge, r_cnt); end
    checks++; if (key_state_n[2] !== 1'b1) begin failures++; $display("FAIL release_level got %b want 1", key_state_n[2]); end
  endtask

  task automatic test_bounce();
    int pulses = 0;
    for (int c = 0; c < 400; c++) begin
      if (c % 20 == 0) key_n[0] = ~key_n[0];
      @(negedge clk);
      checks++; if (dut_v !== mdl_v) begin failures++; $display("FAIL bounce_model cyc %0d got %h want %h", c, dut_v, mdl_v); end
      if (key_pulse_n[0] === 1'b0 || key_rel_pulse_n[0] === 1'b0 || key_state_n[0] !== 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin failures++; $display("FAIL bounce_reject got %0d events want 0", pulses); end
    key_n[0] = 1'b0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      checks++; if (dut_v !== mdl_v) begin failures++; $display("FAIL bounce_hold cyc %0d got %h want %h", c, dut_v, mdl_v); end
      if (key_pulse_n[0] === 1'b0) pulses++;
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL bounce_press got %0d pulses want 1", pulses); end
    key_n[0] = 1'b1;
    repeat (120) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    int hits = 0;
    key_n[1] = 1'b0;
    key_n[3] = 1'b0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      checks++; if (dut_v !== mdl_v) begin failures++; $display("FAIL simul_model cyc %0d got %h want %h", c, dut_v, mdl_v); end
      if (key_pulse_n[1] === 1'b0) begin
        hits++;
        checks++; if ({key_pulse_n, key_valid, key_code} !== 9'b0101_1_0001) begin
          failures++; $display("FAIL simul_pulse got %b/%b/%0d want 0101/1/1", key_pulse_n, key_valid, key_code);
        end
      end
    end
    checks++; if (hits != 1) begin failures++; $display("FAIL simul_count got %0d want 1", hits); end
    key_n = '1;
    repeat (120) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int p_edge = -1, early = 0;
    key_n[0] = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (key_pulse_n !== 4'hF) early++;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({dut_v, early} !== {21'h1FFFE0, 32'd0}) begin failures++; $display("FAIL midreset_idle got %h early %0d want 1fffe0 early 0", dut_v, early); end
    rst_n = 1'b1;
    for (int e = 1; e <= 150; e++) begin
      @(negedge clk);
      checks++; if (dut_v !== mdl_v) begin failures++; $display("FAIL midreset_model edge %0d got %h want %h", e, dut_v, mdl_v); end
      if (key_pulse_n[0] === 1'b0 && p_edge < 0) p_edge = e;
    end
    checks++; if (p_edge != DEB + 2) begin failures++; $display("FAIL midreset_timing got edge %0d want 102", p_edge); end
    key_n[0] = 1'b1;
    repeat (120) @(negedge clk);
  endtask

  task automatic test_random();
    int dur[NK];
    for (int i = 0; i < NK; i++) dur[i] = int'($urandom_range(1, 60));
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NK; i++) begin
        dur[i]--;
        if (dur[i] == 0) begin
          key_n[i] = ~key_n[i];
          dur[i] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 60)) : int'($urandom_range(100, 220));
        end
      end
      rst_n = !(c >= 1500 && c < 1503);
      @(negedge clk);
      checks++; if (dut_v !== mdl_v) begin failures++; $display("FAIL random_model cyc %0d got %h want %h", c, dut_v, mdl_v); end
    end
    key_n = '1;
    rst_n = 1'b1;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      checks++; if (dut_v !== mdl_v) begin failures++; $display("FAIL random_drain cyc %0d got %h want %h", c, dut_v, mdl_v); end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
